// File: rtl/global_history_predictor.sv
// Global-history direction predictor: speculative GHR plus a GHR-indexed table of 2-bit counters.
// Prediction is registered one cycle after PredictReq; no backpressure, every request yields one PredictValid pulse.
module global_history_predictor #(
   parameter int HIST_BITS = 12,
   parameter int CTR_INIT  = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 PredictReq,
   output logic                 PredictValid,
   output logic                 PredictTaken,
   output logic [HIST_BITS-1:0] PredictHistory,
   input  logic                 UpdateValid,
   input  logic                 UpdateTaken,
   input  logic [HIST_BITS-1:0] UpdateHistory,
   input  logic                 UpdateMispredict,
   output logic [HIST_BITS-1:0] GlobalHistory
);

   localparam int ENTRIES = 2**HIST_BITS;

   typedef enum logic [1:0] {
      SNT = 2'd0,
      WNT = 2'd1,
      WT  = 2'd2,
      ST  = 2'd3
   } ctr_state_t;

   localparam ctr_state_t CTR_RST = ctr_state_t'(CTR_INIT[1:0]);

   ctr_state_t           ctr_table [ENTRIES];
   ctr_state_t           upd_cur;
   ctr_state_t           upd_next;
   logic [HIST_BITS-1:0] ghr;
   logic [HIST_BITS-1:0] ghr_next;
   logic                 pred_bit;

   assign pred_bit      = (ctr_table[ghr] == WT) || (ctr_table[ghr] == ST);
   assign upd_cur       = ctr_table[UpdateHistory];
   assign GlobalHistory = ghr;

   always_comb begin
      upd_next = upd_cur;
      case (upd_cur)
         SNT:     upd_next = UpdateTaken ? WNT : SNT;
         WNT:     upd_next = UpdateTaken ? WT  : SNT;
         WT:      upd_next = UpdateTaken ? ST  : WNT;
         ST:      upd_next = UpdateTaken ? ST  : WT;
         default: upd_next = upd_cur;
      endcase
   end

   // A repair overrides the speculative shift from a same-cycle prediction.
   always_comb begin
      ghr_next = ghr;
      if (UpdateValid && UpdateMispredict) begin
         ghr_next = {UpdateHistory[HIST_BITS-2:0], UpdateTaken};
      end else if (PredictReq) begin
         ghr_next = {ghr[HIST_BITS-2:0], pred_bit};
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_table[i] <= CTR_RST;
         end
      end else if (UpdateValid) begin
         ctr_table[UpdateHistory] <= upd_next;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ghr            <= '0;
         PredictValid   <= 1'b0;
         PredictTaken   <= 1'b0;
         PredictHistory <= '0;
      end else begin
         ghr          <= ghr_next;
         PredictValid <= PredictReq;
         if (PredictReq) begin
            PredictTaken   <= pred_bit;
            PredictHistory <= ghr;
         end
      end
   end

endmodule

// File: tb/tb_global_history_predictor.sv
// Bench for global_history_predictor (HIST_BITS=4): directed scenarios plus randomized traffic vs. a reference model.
module tb_global_history_predictor;

   localparam int HB   = 4;
   localparam int NENT = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          req;
   logic          uv;
   logic          ut;
   logic          um;
   logic [HB-1:0] uh;
   logic          PredictValid;
   logic          PredictTaken;
   logic [HB-1:0] PredictHistory;
   logic [HB-1:0] GlobalHistory;

   int errors = 0;
   int checks = 0;

   // Reference model: counters as bounded integers, history as an integer modulo 2**HB.
   int mc [NENT];
   int mg;
   int mvld;
   int mtaken;
   int mhist;

   always #5 clock = ~clock;

   global_history_predictor #(.HIST_BITS(HB), .CTR_INIT(0)) dut (
      .clock           (clock),
      .reset           (reset),
      .PredictReq      (req),
      .PredictValid    (PredictValid),
      .PredictTaken    (PredictTaken),
      .PredictHistory  (PredictHistory),
      .UpdateValid     (uv),
      .UpdateTaken     (ut),
      .UpdateHistory   (uh),
      .UpdateMispredict(um),
      .GlobalHistory   (GlobalHistory)
   );

   task automatic model_reset();
      for (int i = 0; i < NENT; i++) mc[i] = 0;
      mg = 0; mvld = 0; mtaken = 0; mhist = 0;
   endtask

   task automatic drive(input logic r, input logic v, input logic t, input logic m, input int h);
      req = r; uv = v; ut = t; um = m; uh = HB'(h);
   endtask

   // Advance the model using the inputs present before the edge, then move past the edge.
   task automatic tick();
      int t;
      int h;
      t = (mc[mg] >= 2) ? 1 : 0;
      h = int'(uh);
      if (req) begin
         mvld = 1; mtaken = t; mhist = mg;
      end else begin
         mvld = 0;
      end
      if (uv && um)  mg = (h * 2 + int'(ut)) % NENT;
      else if (req)  mg = (mg * 2 + t) % NENT;
      if (uv) begin
         if (ut) mc[h] = (mc[h] < 3) ? mc[h] + 1 : 3;
         else    mc[h] = (mc[h] > 0) ? mc[h] - 1 : 0;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(0, 0, 0, 0, 0);
      model_reset();
      #3;
      checks++; if (PredictValid !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", PredictValid); end
      checks++; if (PredictTaken !== 1'b0) begin errors++; $display("FAIL reset_taken got %b want 0", PredictTaken); end
      checks++; if (PredictHistory !== 4'h0) begin errors++; $display("FAIL reset_hist got %h want 0", PredictHistory); end
      checks++; if (GlobalHistory !== 4'h0) begin errors++; $display("FAIL reset_ghr got %h want 0", GlobalHistory); end
      #9;
      reset = 1'b1;
   endtask

   task automatic test_init_predict();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 0);
         tick();
         checks++; if (PredictValid !== 1'b1) begin errors++; $display("FAIL init_vld[%0d] got %b want 1", i, PredictValid); end
         checks++; if (PredictTaken !== 1'b0) begin errors++; $display("FAIL init_taken[%0d] got %b want 0", i, PredictTaken); end
         checks++; if (PredictHistory !== 4'h0) begin errors++; $display("FAIL init_hist[%0d] got %h want 0", i, PredictHistory); end
         checks++; if (GlobalHistory !== 4'h0) begin errors++; $display("FAIL init_ghr[%0d] got %h want 0", i, GlobalHistory); end
      end
      drive(0, 0, 0, 0, 0);
      tick();
      checks++; if (PredictValid !== 1'b0) begin errors++; $display("FAIL idle_vld got %b want 0", PredictValid); end
   endtask

   task automatic test_train_saturate();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 1, 0, 0);
         tick();
         checks++; if (int'(dut.ctr_table[0]) !== i + 1) begin errors++; $display("FAIL train_ctr[%0d] got %0d want %0d", i, int'(dut.ctr_table[0]), i + 1); end
      end
      checks++; if (GlobalHistory !== 4'h0) begin errors++; $display("FAIL train_ghr got %h want 0", GlobalHistory); end
      drive(1, 0, 0, 0, 0);
      tick();
      checks++; if (PredictTaken !== 1'b1) begin errors++; $display("FAIL train_taken got %b want 1", PredictTaken); end
      checks++; if (PredictHistory !== 4'h0) begin errors++; $display("FAIL train_hist got %h want 0", PredictHistory); end
      checks++; if (GlobalHistory !== 4'h1) begin errors++; $display("FAIL train_ghr_shift got %h want 1", GlobalHistory); end
      for (int i = 0; i < 2; i++) begin
         drive(0, 1, 1, 0, 0);
         tick();
         checks++; if (int'(dut.ctr_table[0]) !== 3) begin errors++; $display("FAIL sat_ctr[%0d] got %0d want 3", i, int'(dut.ctr_table[0])); end
      end
   endtask

   task automatic test_decay();
      int exp_c [4];
      int exp_t [4];
      exp_c = '{2, 1, 0, 0};
      exp_t = '{1, 0, 0, 0};
      // Repair through entry 8 (already 0) to park the GHR at 0 without touching entry 0.
      drive(0, 1, 0, 1, 8);
      tick();
      checks++; if (GlobalHistory !== 4'h0) begin errors++; $display("FAIL decay_park got %h want 0", GlobalHistory); end
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 0, 0, 0);
         tick();
         checks++; if (int'(dut.ctr_table[0]) !== exp_c[i]) begin errors++; $display("FAIL decay_ctr[%0d] got %0d want %0d", i, int'(dut.ctr_table[0]), exp_c[i]); end
         drive(1, 1, 0, 1, 8);
         tick();
         checks++; if (PredictTaken !== exp_t[i][0]) begin errors++; $display("FAIL decay_taken[%0d] got %b want %0d", i, PredictTaken, exp_t[i]); end
         checks++; if (GlobalHistory !== 4'h0) begin errors++; $display("FAIL decay_ghr[%0d] got %h want 0", i, GlobalHistory); end
      end
   endtask

   task automatic test_repair();
      drive(0, 1, 1, 1, 4'b0101);
      tick();
      checks++; if (GlobalHistory !== 4'b1011) begin errors++; $display("FAIL repair_setup got %b want 1011", GlobalHistory); end
      drive(1, 1, 0, 1, 4'b0110);
      tick();
      checks++; if (PredictValid !== 1'b1) begin errors++; $display("FAIL repair_vld got %b want 1", PredictValid); end
      checks++; if (PredictHistory !== 4'b1011) begin errors++; $display("FAIL repair_hist got %b want 1011", PredictHistory); end
      checks++; if (PredictTaken !== 1'b0) begin errors++; $display("FAIL repair_taken got %b want 0", PredictTaken); end
      checks++; if (GlobalHistory !== 4'b1100) begin errors++; $display("FAIL repair_ghr got %b want 1100", GlobalHistory); end
   endtask

   task automatic test_same_entry();
      drive(0, 1, 1, 1, 4'b0010);
      tick();
      checks++; if (GlobalHistory !== 4'b0101) begin errors++; $display("FAIL same_setup got %b want 0101", GlobalHistory); end
      checks++; if (int'(dut.ctr_table[5]) !== 1) begin errors++; $display("FAIL same_pre_ctr got %0d want 1", int'(dut.ctr_table[5])); end
      drive(1, 1, 1, 0, 5);
      tick();
      checks++; if (PredictTaken !== 1'b0) begin errors++; $display("FAIL same_taken got %b want 0", PredictTaken); end
      checks++; if (PredictHistory !== 4'h5) begin errors++; $display("FAIL same_hist got %h want 5", PredictHistory); end
      checks++; if (int'(dut.ctr_table[5]) !== 2) begin errors++; $display("FAIL same_ctr got %0d want 2", int'(dut.ctr_table[5])); end
      checks++; if (GlobalHistory !== 4'b1010) begin errors++; $display("FAIL same_ghr got %b want 1010", GlobalHistory); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) != 0),
               ($urandom_range(0, 3) == 0), int'($urandom_range(0, NENT - 1)));
         tick();
         checks++; if (PredictValid !== mvld[0]) begin errors++; $display("FAIL rnd_vld[%0d] got %b want %0d", i, PredictValid, mvld); end
         checks++; if (PredictTaken !== mtaken[0]) begin errors++; $display("FAIL rnd_taken[%0d] got %b want %0d", i, PredictTaken, mtaken); end
         checks++; if (int'(PredictHistory) !== mhist) begin errors++; $display("FAIL rnd_hist[%0d] got %0d want %0d", i, PredictHistory, mhist); end
         checks++; if (int'(GlobalHistory) !== mg) begin errors++; $display("FAIL rnd_ghr[%0d] got %0d want %0d", i, GlobalHistory, mg); end
      end
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 1, 0, 0);
         tick();
      end
      checks++; if (PredictValid !== 1'b1) begin errors++; $display("FAIL ar_pre_vld got %b want 1", PredictValid); end
      #3;
      reset = 1'b0;
      #1;
      checks++; if (PredictValid !== 1'b0) begin errors++; $display("FAIL ar_vld got %b want 0", PredictValid); end
      checks++; if (PredictTaken !== 1'b0) begin errors++; $display("FAIL ar_taken got %b want 0", PredictTaken); end
      checks++; if (PredictHistory !== 4'h0) begin errors++; $display("FAIL ar_hist got %h want 0", PredictHistory); end
      checks++; if (GlobalHistory !== 4'h0) begin errors++; $display("FAIL ar_ghr got %h want 0", GlobalHistory); end
      model_reset();
      drive(0, 0, 0, 0, 0);
      #10;
      reset = 1'b1;
      drive(1, 0, 0, 0, 0);
      tick();
      checks++; if (PredictValid !== 1'b1) begin errors++; $display("FAIL ar_post_vld got %b want 1", PredictValid); end
      checks++; if (PredictTaken !== 1'b0) begin errors++; $display("FAIL ar_post_taken got %b want 0", PredictTaken); end
      checks++; if (PredictHistory !== 4'h0) begin errors++; $display("FAIL ar_post_hist got %h want 0", PredictHistory); end
      drive(0, 0, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_init_predict();
      test_train_saturate();
      test_decay();
      test_repair();
      test_same_entry();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
